// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of a 1024x32 word RAM with
// a registered read. It handles byte/half/word loads (with sign or zero
// extension) and stores. Byte and halfword stores use read-modify-write.
// It returns one response per accepted request.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_we,
  input  logic [31:0]           mem_q
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LOAD = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  // Lane datapath: the byte shift derived from the registered lane. The lane
  // is always even for a legal halfword, so a shift of lane*8 also selects the
  // correct half.
  logic [4:0]  lane_sh;
  logic [31:0] q_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic        req_bad;

  assign lane_sh   = {lane_q, 3'b000};
  assign q_shifted = mem_q >> lane_sh;

  // Alignment / size legality of the incoming request
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Load extraction and extension from the RAM word
  always_comb begin
    load_ext = mem_q;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & q_shifted[7]}}, q_shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & q_shifted[15]}}, q_shifted[15:0]};
      default: load_ext = mem_q;
    endcase
  end

  // RMW merge: replace the target lane(s) of the old word with store data
  always_comb begin
    lane_mask = (size_q == 2'b00) ? (32'h0000_00ff << lane_sh)
                                  : (32'h0000_ffff << lane_sh);
    merged    = (mem_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  // Next-state and request capture
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr[ADDR_WIDTH+1:2];
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata;
          err_d    = req_bad;
          if (req_bad) begin
            rdata_d = 32'h0;
            state_d = S_RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = we_q ? S_WR : S_LOAD;
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_WR: begin
        rdata_d = 32'h0;
        state_d = S_RESP;
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      lane_q   <= 2'b00;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded from state. mem_we is combinational so an async reset
  // removes it immediately.
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    resp_valid     = (state_q == S_RESP);
    resp_err       = (state_q == S_RESP) & err_q;
    resp_rdata     = rdata_q;
    mem_read_addr  = addr_q;
    mem_write_addr = addr_q;
    mem_we         = (state_q == S_WR);
    mem_data       = 32'h0;
    if (state_q == S_WR) mem_data = (size_q == 2'b10) ? wdata_q : merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural RAM plus a reference memory
// image. Expected load data, errors and latencies are computed directly from
// the access rules.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_read_addr, mem_write_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] ram   [1024];
  logic [31:0] model [1024];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_q(mem_q)
  );

  // Registered-read RAM; a read during a write returns the old data
  always @(posedge clk) begin
    if (mem_we) ram[mem_write_addr] <= mem_data;
    mem_q <= ram[mem_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request, end to end. The reference model decides the outcome from
  // the access rules alone.
  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [11:0] a, input logic [31:0] wd, input string tag);
    logic        e;
    logic [31:0] exp_rd, old, word, mask;
    int          exp_lat, exp_we_at, lat, we_cnt, we_at, off;
    old  = model[a[11:2]];
    off  = (sz == 2'b01) ? 16 * a[1] : 8 * a[1:0];
    e    = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0);
    exp_rd = 0; exp_lat = 1; exp_we_at = -1;
    if (!e && !we) begin
      word = old >> off;
      if (sz == 2'b00)      exp_rd = sg ? 32'(signed'(word[7:0]))  : 32'(word[7:0]);
      else if (sz == 2'b01) exp_rd = sg ? 32'(signed'(word[15:0])) : 32'(word[15:0]);
      else                  exp_rd = old;
      exp_lat = 3;
    end else if (!e && sz == 2'b10) begin
      model[a[11:2]] = wd;
      exp_lat = 2; exp_we_at = 1;
    end else if (!e) begin
      mask = ((sz == 2'b00) ? 32'hff : 32'hffff) << off;
      model[a[11:2]] = (old & ~mask) | ((wd << off) & mask);
      exp_lat = 3; exp_we_at = 2;
    end

    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 1);
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    lat = -1; we_cnt = 0; we_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_at = i; end
      if (resp_valid) begin
        lat = i;
        req_valid = 0;
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, 32'(resp_err), 32'(e));
        break;
      end
      // junk on the request bus while busy must be ignored
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = 12'($urandom); req_wdata = $urandom;
    end
    req_valid = 0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " we_count"}, 32'(we_cnt), (exp_we_at < 0) ? 0 : 1);
    chk({tag, " we_cycle"}, 32'(we_at), 32'(exp_we_at));
    @(negedge clk);
    chk({tag, " post_valid"}, 32'(resp_valid), 0);
    chk({tag, " post_err"}, 32'(resp_err), 0);
  endtask

  initial begin
    int nmis;
    logic [31:0] w8;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      model[i] = ram[i];
    end
    ram[5] = 32'h8899AABB; model[5] = 32'h8899AABB;

    // Reset state
    #12;
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst resp_err", 32'(resp_err), 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_data", mem_data, 0);
    chk("rst mem_raddr", 32'(mem_read_addr), 0);
    chk("rst mem_waddr", 32'(mem_write_addr), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 1);

    // Directed cases
    txn(0, 2'b00, 1, 12'h015, 0, "lb_s");
    txn(0, 2'b01, 0, 12'h016, 0, "lh_u");
    txn(0, 2'b10, 0, 12'h014, 0, "lw");
    txn(1, 2'b00, 0, 12'h017, 32'h0000005C, "sb");
    txn(0, 2'b10, 0, 12'h014, 0, "lw_after_sb");
    chk("sb word5", model[5], 32'h5C99AABB);
    txn(1, 2'b10, 0, 12'hFFC, 32'hDEADBEEF, "sw_top");
    txn(0, 2'b10, 0, 12'hFFC, 0, "lw_top");
    w8 = model[8];
    txn(1, 2'b01, 0, 12'h021, 32'h1234, "sh_mis");
    txn(1, 2'b10, 0, 12'h022, 32'hCAFEF00D, "sw_mis");
    txn(1, 2'b11, 0, 12'h020, 32'h55555555, "sz_ill");
    chk("word8 kept", ram[8], w8);
    txn(1, 2'b01, 0, 12'h01E, 32'hFFFFA5A5, "sh_hi");
    txn(0, 2'b01, 1, 12'h01E, 0, "lh_s_hi");

    // Reset in the RD state of a byte store
    w8 = model[5];
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b00; req_addr = 12'h014; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; rst_n = 0;
    #1;
    chk("midrst mem_we", 32'(mem_we), 0);
    chk("midrst resp_valid", 32'(resp_valid), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("midrst ready", 32'(req_ready), 1);
    chk("midrst no_resp", 32'(resp_valid), 0);
    chk("midrst ram5", ram[5], w8);
    txn(0, 2'b10, 0, 12'h014, 0, "lw_after_rst");

    // Randomized traffic focused on a few low and high words
    for (int n = 0; n < 250; n++) begin
      logic [11:0] a;
      a[1:0]  = 2'($urandom);
      a[11:2] = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 11))
                                            : 10'($urandom_range(1018, 1023));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "rnd");
    end

    nmis = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== model[i]) nmis++;
    chk("ram_image", 32'(nmis), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end
endmodule
